// File: rtl/route_comp_pipe.sv
// Elastic route-computation stage: dimension-order torus routing, per-packet dir/VC state, output queue with eject port.
// Optional feature macro RC_PRIORITY_DEC_EN: decrement (saturating) the cmp field of head and single flits.
module route_comp_pipe #(
  parameter int XSIZE      = 4,
  parameter int YSIZE      = 4,
  parameter int ZSIZE      = 4,
  parameter int XW         = 2,
  parameter int YW         = 2,
  parameter int ZW         = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int CUR_Z      = 0,
  parameter int FLIT_SIZE  = 64,
  parameter int CMP_LEN    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLIT_SIZE-1:0] in_flit,
  input  logic [2:0]           dir_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic [2:0]           dir_out,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [FLIT_SIZE-1:0] ej_flit,
  output logic                 pkt_err
);

  localparam int VC_B   = FLIT_SIZE - 3;
  localparam int Z_LO   = VC_B - ZW;
  localparam int Y_LO   = Z_LO - YW;
  localparam int X_LO   = Y_LO - XW;
  localparam int CMP_LO = X_LO - CMP_LEN;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam int unsigned CX = CUR_X;
  localparam int unsigned CY = CUR_Y;
  localparam int unsigned CZ = CUR_Z;
  localparam int unsigned SX = XSIZE;
  localparam int unsigned SY = YSIZE;
  localparam int unsigned SZ = ZSIZE;

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;
  localparam logic [2:0] D_EJECT  = 3'd6;

  typedef enum logic {IDLE, PKT} state_t;

  state_t state, state_n;

  function automatic int unsigned fwd_dist(input int unsigned dst, input int unsigned cur,
                                           input int unsigned size);
    return (dst >= cur) ? dst - cur : dst + size - cur;
  endfunction

`ifdef RC_PRIORITY_DEC_EN
  function automatic logic [CMP_LEN-1:0] prio_dec(input logic [CMP_LEN-1:0] c);
    return (c == '0) ? c : c - CMP_LEN'(1);
  endfunction
`endif

  // p0: classify, route and rewrite the accepted flit
  logic [1:0]           typ_p0;
  logic                 accept_p0, vld_p0;
  logic                 drop_p0, err_p0, latch_p0, use_lat_p0;
  int unsigned          dx_p0, dy_p0, dz_p0;
  logic [2:0]           rdir_p0, dir_p0;
  logic                 wrap_p0, pos_p0, rvc_p0;
  logic [CMP_LEN-1:0]   cmp_p0;
  logic [FLIT_SIZE-1:0] flit_p0;
  logic [2:0]           dir_lat;
  logic                 vc_lat;

  assign typ_p0    = in_flit[FLIT_SIZE-1 -: 2];
  assign accept_p0 = in_valid && in_ready;
  assign vld_p0    = accept_p0 && !drop_p0;

  always_comb begin
    dx_p0   = 32'(in_flit[X_LO +: XW]);
    dy_p0   = 32'(in_flit[Y_LO +: YW]);
    dz_p0   = 32'(in_flit[Z_LO +: ZW]);
    rdir_p0 = D_EJECT;
    wrap_p0 = 1'b0;
    pos_p0  = 1'b0;
    if (dx_p0 != CX) begin
      pos_p0  = fwd_dist(dx_p0, CX, SX) <= SX / 2;
      rdir_p0 = pos_p0 ? 3'd0 : 3'd3;
      wrap_p0 = pos_p0 ? (CX == SX - 1) : (CX == 0);
    end else if (dy_p0 != CY) begin
      pos_p0  = fwd_dist(dy_p0, CY, SY) <= SY / 2;
      rdir_p0 = pos_p0 ? 3'd1 : 3'd4;
      wrap_p0 = pos_p0 ? (CY == SY - 1) : (CY == 0);
    end else if (dz_p0 != CZ) begin
      pos_p0  = fwd_dist(dz_p0, CZ, SZ) <= SZ / 2;
      rdir_p0 = pos_p0 ? 3'd2 : 3'd5;
      wrap_p0 = pos_p0 ? (CZ == SZ - 1) : (CZ == 0);
    end
    // Dateline VC switch only when continuing straight across the wrap link.
    rvc_p0 = in_flit[VC_B];
    if (rdir_p0 != D_EJECT) begin
      if (dir_in != rdir_p0) rvc_p0 = 1'b0;
      else if (wrap_p0)      rvc_p0 = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    drop_p0    = 1'b0;
    err_p0     = 1'b0;
    latch_p0   = 1'b0;
    use_lat_p0 = 1'b0;
    case (state)
      IDLE: begin
        case (typ_p0)
          T_HEAD: begin
            latch_p0 = 1'b1;
            state_n  = PKT;
          end
          T_SINGLE: ;
          default: begin
            drop_p0 = 1'b1;
            err_p0  = 1'b1;
          end
        endcase
      end
      PKT: begin
        case (typ_p0)
          T_BODY: use_lat_p0 = 1'b1;
          T_TAIL: begin
            use_lat_p0 = 1'b1;
            state_n    = IDLE;
          end
          T_HEAD: begin
            err_p0   = 1'b1;
            latch_p0 = 1'b1;
          end
          default: begin
            err_p0  = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
`ifdef RC_PRIORITY_DEC_EN
    cmp_p0 = prio_dec(in_flit[CMP_LO +: CMP_LEN]);
`else
    cmp_p0 = in_flit[CMP_LO +: CMP_LEN];
`endif
    flit_p0 = in_flit;
    if (use_lat_p0) begin
      flit_p0[VC_B] = vc_lat;
      dir_p0        = dir_lat;
    end else begin
      flit_p0[VC_B]                 = rvc_p0;
      flit_p0[CMP_LO +: CMP_LEN]    = cmp_p0;
      dir_p0                        = rdir_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= accept_p0 && err_p0;
      if (accept_p0) state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0 && latch_p0) begin
      dir_lat <= rdir_p0;
      vc_lat  <= rvc_p0;
    end
  end

  // p1: output queue; head steered to crossbar or eject port by its dir
  logic [FLIT_SIZE-1:0] q_flit_p1 [FIFO_DEPTH];
  logic [2:0]           q_dir_p1  [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          cnt;
  logic                 vld_p1, pop_p1;
  logic [FLIT_SIZE-1:0] head_flit_p1;
  logic [2:0]           head_dir_p1;

  assign in_ready     = cnt != (AW+1)'(FIFO_DEPTH);
  assign vld_p1       = cnt != '0;
  assign head_flit_p1 = q_flit_p1[rd_ptr];
  assign head_dir_p1  = q_dir_p1[rd_ptr];
  assign out_valid    = vld_p1 && (head_dir_p1 != D_EJECT);
  assign ej_valid     = vld_p1 && (head_dir_p1 == D_EJECT);
  assign out_flit     = out_valid ? head_flit_p1 : '0;
  assign dir_out      = out_valid ? head_dir_p1 : 3'd0;
  assign ej_flit      = ej_valid ? head_flit_p1 : '0;
  assign pop_p1       = (out_valid && out_ready) || (ej_valid && ej_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + AW'(1);
      if (pop_p1) rd_ptr <= rd_ptr + AW'(1);
      case ({vld_p0, pop_p1})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      q_flit_p1[wr_ptr] <= flit_p0;
      q_dir_p1[wr_ptr]  <= dir_p0;
    end
  end

endmodule

// File: tb/tb_route_comp_pipe.sv
// Scoreboard bench for route_comp_pipe: two instances, CUR=(1,1,1) and CUR=(3,0,0), on a 4x4x4 torus.
module tb_route_comp_pipe;

  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, S = 2'b11;
`ifdef RC_PRIORITY_DEC_EN
  localparam logic [3:0] E5 = 4'd4;
`else
  localparam logic [3:0] E5 = 4'd5;
`endif

  typedef struct packed {
    logic [2:0]  d;
    logic [63:0] f;
  } exp_t;

  logic        clk, rst_n;
  logic        iv_a, ir_a, ov_a, or_a, ev_a, er_a, pe_a;
  logic [63:0] if_a, of_a, ef_a;
  logic [2:0]  di_a, do_a;
  logic        iv_b, ir_b, ov_b, or_b, ev_b, er_b, pe_b;
  logic [63:0] if_b, of_b, ef_b;
  logic [2:0]  di_b, do_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  route_comp_pipe #(.CUR_X(1), .CUR_Y(1), .CUR_Z(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_flit(if_a), .dir_in(di_a),
    .out_valid(ov_a), .out_ready(or_a), .out_flit(of_a), .dir_out(do_a),
    .ej_valid(ev_a), .ej_ready(er_a), .ej_flit(ef_a), .pkt_err(pe_a));

  route_comp_pipe #(.CUR_X(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_flit(if_b), .dir_in(di_b),
    .out_valid(ov_b), .out_ready(or_b), .out_flit(of_b), .dir_out(do_b),
    .ej_valid(ev_b), .ej_ready(er_b), .ej_flit(ef_b), .pkt_err(pe_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [1:0] t, input logic vc, input logic [1:0] z,
                                     input logic [1:0] y, input logic [1:0] x,
                                     input logic [3:0] c, input logic [15:0] pl);
    return {t, vc, z, y, x, c, 35'd0, pl};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic send(input bit b, input logic [63:0] f, input logic [2:0] d, output logic err);
    int n = 0;
    if (b) begin iv_b = 1'b1; if_b = f; di_b = d; end
    else   begin iv_a = 1'b1; if_a = f; di_a = d; end
    forever begin
      @(negedge clk);
      if (b ? ir_b : ir_a) break;
      n++;
      if (n > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never rose");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (b) iv_b = 1'b0; else iv_a = 1'b0;
    err = b ? pe_b : pe_a;
  endtask

  task automatic issue(input string nm, input bit b, input logic [63:0] f, input logic [2:0] d,
                       input bit push, input logic [2:0] ed, input logic [63:0] ef,
                       input logic exp_err);
    logic err;
    exp_t e;
    e.d = ed;
    e.f = ef;
    if (push) begin
      if (b) sb_b.push_back(e); else sb_a.push_back(e);
    end
    send(b, f, d, err);
    chk({nm, "_err"}, 128'(err), 128'(exp_err));
  endtask

  // Monitors: compare every completed output transfer against the scoreboard.
  always @(negedge clk) begin
    exp_t got, e;
    if (rst_n && (ov_a || ev_a)) begin
      chk("a_excl", 128'(ov_a & ev_a), 128'(0));
      if ((ov_a && or_a) || (ev_a && er_a)) begin
        got.d = ov_a ? do_a : 3'd6;
        got.f = ov_a ? of_a : ef_a;
        if (sb_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected: got %0h, expected nothing", got);
        end else begin
          e = sb_a.pop_front();
          chk("a_out", 128'(got), 128'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t got, e;
    if (rst_n && (ov_b || ev_b)) begin
      chk("b_excl", 128'(ov_b & ev_b), 128'(0));
      if ((ov_b && or_b) || (ev_b && er_b)) begin
        got.d = ov_b ? do_b : 3'd6;
        got.f = ov_b ? of_b : ef_b;
        if (sb_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got %0h, expected nothing", got);
        end else begin
          e = sb_b.pop_front();
          chk("b_out", 128'(got), 128'(e));
        end
      end
    end
  end

  initial begin
    exp_t dummy;
    logic err3;
    int   n;
    rst_n = 1'b0;
    iv_a = 0; if_a = '0; di_a = 3'd7; or_a = 1'b1; er_a = 1'b1;
    iv_b = 0; if_b = '0; di_b = 3'd7; or_b = 1'b1; er_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(ir_a), 128'(1));
    chk("rst_out_valid", 128'(ov_a), 128'(0));
    chk("rst_ej_valid", 128'(ev_a), 128'(0));
    chk("rst_pkt_err", 128'(pe_a), 128'(0));
    chk("rst_out_flit", 128'(of_a), 128'(0));
    chk("rst_ej_flit", 128'(ef_a), 128'(0));
    chk("rst_dir_out", 128'(do_a), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // X routing from (1,1,1): tie goes POS, distance 3 goes NEG; injection clears VC
    issue("a_h_xpos", 0, mk(H,1,1,1,3,5,1), 3'd7, 1, 3'd0, mk(H,0,1,1,3,E5,1), 0);
    issue("a_t_xpos", 0, mk(T,1,0,0,0,5,2), 3'd0, 1, 3'd0, mk(T,0,0,0,0,5,2), 0);
    issue("a_h_xneg", 0, mk(H,0,1,1,0,5,3), 3'd7, 1, 3'd3, mk(H,0,1,1,0,E5,3), 0);
    issue("a_t_xneg", 0, mk(T,1,0,0,0,5,4), 3'd0, 1, 3'd3, mk(T,0,0,0,0,5,4), 0);

    // Wrap crossing at CUR_X=3 continuing XPOS moves to VC 1; body/tail follow
    issue("b_h_wrap", 1, mk(H,0,0,0,1,5,5), 3'd0, 1, 3'd0, mk(H,1,0,0,1,E5,5), 0);
    issue("b_b_wrap", 1, mk(B,0,0,0,0,5,6), 3'd0, 1, 3'd0, mk(B,1,0,0,0,5,6), 0);
    issue("b_t_wrap", 1, mk(T,0,0,0,0,5,7), 3'd0, 1, 3'd0, mk(T,1,0,0,0,5,7), 0);

    // Eject packet: VC kept, cmp 0 saturates
    issue("a_h_ej", 0, mk(H,1,1,1,1,0,8), 3'd2, 1, 3'd6, mk(H,1,1,1,1,0,8), 0);
    issue("a_b_ej", 0, mk(B,0,0,0,0,5,9), 3'd2, 1, 3'd6, mk(B,1,0,0,0,5,9), 0);
    issue("a_t_ej", 0, mk(T,0,0,0,0,5,10), 3'd2, 1, 3'd6, mk(T,1,0,0,0,5,10), 0);

    // Protocol errors
    issue("a_b_idle", 0, mk(B,0,0,0,0,5,11), 3'd7, 0, 3'd0, '0, 1);
    issue("a_h_pkt1", 0, mk(H,0,1,1,3,5,12), 3'd7, 1, 3'd0, mk(H,0,1,1,3,E5,12), 0);
    issue("a_h_pkt2", 0, mk(H,1,1,2,1,5,13), 3'd7, 1, 3'd1, mk(H,0,1,2,1,E5,13), 1);
    issue("a_t_pkt2", 0, mk(T,1,0,0,0,5,14), 3'd7, 1, 3'd1, mk(T,0,0,0,0,5,14), 0);
    issue("a_s_ystr", 0, mk(S,1,1,2,1,5,15), 3'd1, 1, 3'd1, mk(S,1,1,2,1,E5,15), 0);
    issue("a_s_zneg", 0, mk(S,0,0,1,1,5,16), 3'd7, 1, 3'd5, mk(S,0,0,1,1,E5,16), 0);
    issue("a_h_pkt3", 0, mk(H,0,1,1,3,5,17), 3'd7, 1, 3'd0, mk(H,0,1,1,3,E5,17), 0);
    issue("a_s_inpkt", 0, mk(S,0,1,1,0,5,18), 3'd7, 1, 3'd3, mk(S,0,1,1,0,E5,18), 1);
    issue("a_b_after", 0, mk(B,0,0,0,0,5,19), 3'd7, 0, 3'd0, '0, 1);

    // Back-pressure: two flits fill the queue, the third waits
    repeat (4) @(posedge clk);
    #1;
    or_a = 1'b0;
    issue("a_st1", 0, mk(S,0,1,1,3,5,20), 3'd7, 1, 3'd0, mk(S,0,1,1,3,E5,20), 0);
    issue("a_st2", 0, mk(S,0,1,1,0,5,21), 3'd7, 1, 3'd3, mk(S,0,1,1,0,E5,21), 0);
    chk("a_full_in_ready", 128'(ir_a), 128'(0));
    chk("a_stall_dir", 128'(do_a), 128'(0));
    chk("a_stall_flit", 128'(of_a), 128'(mk(S,0,1,1,3,E5,20)));
    fork
      issue("a_st3", 0, mk(S,0,1,1,3,5,22), 3'd7, 1, 3'd0, mk(S,0,1,1,3,E5,22), 0);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("a_still_full", 128'(ir_a), 128'(0));
        or_a = 1'b1;
      end
    join

    // Reset mid-packet flushes the queue and returns to IDLE
    repeat (5) @(posedge clk);
    #1;
    or_a = 1'b0;
    issue("a_h_rst", 0, mk(H,0,1,1,3,5,23), 3'd7, 1, 3'd0, mk(H,0,1,1,3,E5,23), 0);
    rst_n = 1'b0;
    #1;
    chk("a_rst_out_valid", 128'(ov_a), 128'(0));
    chk("a_rst_in_ready", 128'(ir_a), 128'(1));
    dummy = sb_a.pop_back();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_a = 1'b1;
    issue("a_b_postrst", 0, mk(B,0,0,0,0,5,24), 3'd7, 0, 3'd0, '0, 1);
    issue("a_s_postrst", 0, mk(S,0,1,1,1,5,25), 3'd7, 1, 3'd6, mk(S,0,1,1,1,E5,25), 0);

    n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_a_drained", 128'(sb_a.size()), 128'(0));
    chk("sb_b_drained", 128'(sb_b.size()), 128'(0));
    err3 = pe_a;
    chk("a_err_quiet", 128'(err3), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/route_comp_pipe.md
# route_comp_pipe

Parametrised, elastic route-computation stage for the 3D-torus router input path. It replaces the fixed single-register RC stage with three additions: valid/ready handshaking on every side, a FIFO_DEPTH-entry output queue so that stalls never drop flits, and a dedicated eject port. Head and single flits are routed with minimal dimension-order (X, then Y, then Z) torus routing. Direction and VC-class state is held per packet for the wormhole body, and protocol errors are flagged.

## Interface
- XSIZE, YSIZE, ZSIZE, default 4: torus extent per dimension (≥2).
- XW, YW, ZW, default 2: coordinate field widths.
- CUR_X, CUR_Y, CUR_Z, default 0: this router's coordinates.
- FLIT_SIZE, default 64: flit width.
- CMP_LEN, default 4: priority (remaining-hop) field width.
- FIFO_DEPTH, default 2: output queue depth (power of two, ≥2).
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_flit is valid.
- in_ready  output  1  stage accepts; transfer when in_valid && in_ready.
- in_flit  input  FLIT_SIZE  incoming flit.
- dir_in  input  3  direction the packet travelled on its last hop; 7 = local injection.
- out_valid  output  1  head of queue valid for the crossbar.
- out_ready  input  1  crossbar accepts.
- out_flit  output  FLIT_SIZE  routed flit.
- dir_out  output  3  output port for out_flit.
- ej_valid  output  1  head of queue valid for ejection.
- ej_ready  input  1  ejection sink accepts.
- ej_flit  output  FLIT_SIZE  ejected flit.
- pkt_err  output  1  one-cycle protocol-error pulse.

## Operation
- Flit layout (MSB first): type[2] (00 head, 01 body, 10 tail, 11 single), vc[1], dst_z[ZW], dst_y[YW], dst_x[XW], cmp[CMP_LEN], payload.
- Direction codes: 0 XPOS, 1 YPOS, 2 ZPOS, 3 XNEG, 4 YNEG, 5 ZNEG, 6 EJECT.
- Routing for the first unequal dimension d: dist = (dst_d − cur_d) mod SIZE_d. If dist ≤ SIZE_d/2 the port is POS, otherwise NEG. When all three dimensions match, the port is EJECT.
- VC class, computed for head and single flits only:
  - Dimension change or injection (dir_in ≠ dir): vc = 0.
  - Same direction, and the hop crosses the wrap link (POS at cur = SIZE−1, NEG at cur = 0): vc = 1.
  - Same direction, no wrap crossing: vc is unchanged.
  - EJECT: vc is unchanged.
- FSM states:
  - IDLE: head → latch dir/vc, go to PKT. Single → route, stay in IDLE. Body/tail → accept, drop, pulse pkt_err.
  - PKT: body → use the latched dir and vc. Tail → same, then go to IDLE. Head → pulse pkt_err, treat as a new head, stay in PKT. Single → pulse pkt_err, route it, go to IDLE.
- Every non-dropped accepted flit is written to the queue with its dir. The queue head drives out_* when dir ≠ EJECT, and ej_* when dir = EJECT. out_valid and ej_valid are never high together.
- in_ready = queue not full. Simultaneous push and pop at full is not allowed, because in_ready is already low at full.

## Timing
- Reset values: in_ready 1; out_valid, ej_valid and pkt_err 0; out_flit, ej_flit and dir_out 0; FSM IDLE; queue empty.
- Latency: a flit accepted in cycle n is visible at an output in cycle n+1 when the queue was empty. There is no combinational in→out path.
- Throughput: one flit per cycle while the draining port is ready.
- The queue-head outputs hold stable while valid && !ready.
- pkt_err is asserted in the cycle after the offending flit is accepted.
- Reset asserted mid-packet clears the queue and returns the FSM to IDLE immediately.

## Configuration
- RC_PRIORITY_DEC_EN defined: cmp of head and single flits is decremented by 1, saturating at 0. Body and tail flits pass unchanged.
- RC_PRIORITY_DEC_EN undefined: cmp passes unmodified for all flits.

## Test plan
- 4×4×4 torus, CUR = (1,1,1), dir_in 7, head dst (3,1,1) → dir_out 0 (XPOS, dist 2 tie), vc 0. Head dst (0,1,1) → dir_out 3 (XNEG).
- CUR_X = 3, dir_in 0, head dst (1,0,0) with vc 0 → dir_out 0, vc 1. The following body flits take dir 0 and vc 1.
- CUR = (1,1,1), packet head/body/tail to (1,1,1) → three flits on ej_*, out_valid stays 0, FSM back to IDLE.
- out_ready held 0, three back-to-back flits offered → two accepted, in_ready 0 in the cycle after the second accept. Release → flits emerge in order with no loss or duplication.
- Body flit while IDLE → pkt_err pulse, no output. Head in PKT → pkt_err pulse, rerouted as a new head.
- With RC_PRIORITY_DEC_EN: head cmp 5 → 4, head cmp 0 → 0, body cmp 5 → 5. Without the macro: head cmp 5 → 5.
